mem_arbiter: RTL and testbench

Arbitrates a single shared multi-cycle main memory between the instruction-side and data-side cache miss handlers of the pipelined CPU. It grants one requester at a time. For cache refills it issues a pipelined burst of 8 word reads, then steers the returning words back to the granted side with a word index. It also performs single-word data-side writes for write-through stores. It sits between the two cache controllers and the 4-cycle memory model.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one multi-cycle main memory between the I-side and
//             D-side cache miss handlers. Refills issue a pipelined burst of
//             WORDS reads and steer the returning words (with an index) back
//             to the granted side; D-side write-through stores are performed
//             as single-cycle writes. Round-robin between the two sides when
//             both request in the same IDLE cycle.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             i_req/i_addr          - I-side refill request and miss address
//             i_grant/i_data_valid/i_done - I-side grant, word strobe, last word
//             d_req/d_wr/d_addr/d_wdata - D-side request (refill or write)
//             d_grant/d_data_valid/d_done - D-side equivalents
//             fill_word/fill_data   - index and value of the returning word
//             mem_*                 - memory command and read-return ports
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [15:0]                i_addr,
    output logic                       i_grant,
    output logic                       i_data_valid,
    output logic                       i_done,
    input  logic                       d_req,
    input  logic                       d_wr,
    input  logic [15:0]                d_addr,
    input  logic [15:0]                d_wdata,
    output logic                       d_grant,
    output logic                       d_data_valid,
    output logic                       d_done,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic [15:0]                fill_data,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_data_out,
    output logic                       mem_enable,
    output logic                       mem_wr,
    input  logic [15:0]                mem_data_in,
    input  logic                       mem_data_valid
);

    localparam int c_IDX_W = $clog2(WORDS);
    localparam int c_CNT_W = c_IDX_W + 1;

    localparam logic [c_CNT_W-1:0] c_WORDS_CNT = c_CNT_W'(WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(WORDS - 1);
    // Clears the byte-in-block offset so refills start at the block boundary.
    localparam logic [15:0]        c_BLK_MASK  = ~16'(2 * WORDS - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_I_FILL  = 2'd1;
    localparam logic [1:0] c_D_FILL  = 2'd2;
    localparam logic [1:0] c_D_WRITE = 2'd3;

    if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0)) begin : g_check_words
        $error("mem_arbiter: WORDS must be a power of 2 and at least 2");
    end
    if (MEM_LAT < 1) begin : g_check_lat
        $error("mem_arbiter: MEM_LAT must be at least 1");
    end

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_issue_cnt;
    logic [c_IDX_W-1:0]  r_recv_cnt;
    logic [15:0]         r_base;
    logic                r_last_d;

    logic w_fill;
    logic w_issue;
    logic w_recv;
    logic w_last_word;
    logic w_pick_d;

    assign w_fill      = (r_state == c_I_FILL) || (r_state == c_D_FILL);
    // issue_cnt saturates at WORDS; from then on the fill only drains returns.
    assign w_issue     = w_fill && (r_issue_cnt < c_WORDS_CNT);
    // Returns outside a fill (IDLE, D_WRITE, after a reset) are dropped here.
    assign w_recv      = w_fill && mem_data_valid;
    assign w_last_word = w_recv && (r_recv_cnt == c_LAST_IDX);
    // D wins a tie unless it won the previous arbitration.
    assign w_pick_d    = d_req && !(i_req && r_last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_base      <= '0;
            r_last_d    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pick_d) begin
                        r_last_d <= 1'b1;
                        if (d_wr) begin
                            r_state <= c_D_WRITE;
                            r_base  <= d_addr;
                        end else begin
                            r_state <= c_D_FILL;
                            r_base  <= d_addr & c_BLK_MASK;
                        end
                    end else if (i_req) begin
                        r_last_d <= 1'b0;
                        r_state  <= c_I_FILL;
                        r_base   <= i_addr & c_BLK_MASK;
                    end
                end
                c_I_FILL, c_D_FILL: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
                    end
                    if (mem_data_valid) begin
                        if (w_last_word) begin
                            r_state     <= c_IDLE;
                            r_issue_cnt <= '0;
                            r_recv_cnt  <= '0;
                        end else begin
                            r_recv_cnt  <= r_recv_cnt + c_IDX_W'(1);
                        end
                    end
                end
                c_D_WRITE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign i_grant      = (r_state == c_I_FILL);
    assign d_grant      = (r_state == c_D_FILL) || (r_state == c_D_WRITE);

    assign i_data_valid = w_recv && (r_state == c_I_FILL);
    assign d_data_valid = w_recv && (r_state == c_D_FILL);
    assign i_done       = w_last_word && (r_state == c_I_FILL);
    assign d_done       = (w_last_word && (r_state == c_D_FILL)) || (r_state == c_D_WRITE);

    assign fill_word    = r_recv_cnt;
    assign fill_data    = mem_data_in;

    assign mem_enable   = w_issue || (r_state == c_D_WRITE);
    assign mem_wr       = (r_state == c_D_WRITE);
    assign mem_addr     = w_issue ? {r_base[15:c_IDX_W+1], r_issue_cnt[c_IDX_W-1:0], 1'b0} :
                          (r_state == c_D_WRITE) ? r_base : 16'h0000;
    assign mem_data_out = (r_state == c_D_WRITE) ? d_wdata : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A behavioural memory with
//             MEM_LAT read latency sits on the memory port; expected traces are
//             derived per transaction from the arbitration and burst timing
//             rules, with directed scenarios followed by random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int WORDS   = 8;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_grant, i_data_valid, i_done;
    logic        d_req, d_wr;
    logic [15:0] d_addr, d_wdata;
    logic        d_grant, d_data_valid, d_done;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic [15:0] mem_addr, mem_data_out, mem_data_in;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic        inject;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    bit model_last_d;
    logic [15:0] ref_ov [256];

    mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
        .i_data_valid(i_data_valid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data_valid(d_data_valid), .d_done(d_done),
        .fill_word(fill_word), .fill_data(fill_data),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed hash of the address, overlaid by stored writes.
    function automatic logic [15:0] base_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // ---------------- behavioural memory ----------------
    logic        mvp [MEM_LAT];
    logic [15:0] mdp [MEM_LAT];
    logic [15:0] mem_ov [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) mvp[i] <= 1'b0;
            for (int i = 0; i < 256; i++) mem_ov[i] <= 16'h0000;
        end else begin
            mvp[0] <= mem_enable && !mem_wr;
            mdp[0] <= base_word(mem_addr) ^ mem_ov[mem_addr[8:1]];
            for (int i = 1; i < MEM_LAT; i++) begin
                mvp[i] <= mvp[i-1];
                mdp[i] <= mdp[i-1];
            end
            if (mem_enable && mem_wr)
                mem_ov[mem_addr[8:1]] <= mem_data_out ^ base_word(mem_addr);
        end
    end

    assign mem_data_valid = mvp[MEM_LAT-1] | inject;
    assign mem_data_in    = inject ? 16'hDEAD : mdp[MEM_LAT-1];

    // ---------------- reference and checks ----------------
    function automatic logic [15:0] ref_word(input logic [15:0] a);
        return base_word(a) ^ ref_ov[a[8:1]];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".i_grant"},  i_grant, 0);
        chk({tag, ".d_grant"},  d_grant, 0);
        chk({tag, ".i_valid"},  i_data_valid, 0);
        chk({tag, ".d_valid"},  d_data_valid, 0);
        chk({tag, ".i_done"},   i_done, 0);
        chk({tag, ".d_done"},   d_done, 0);
        chk({tag, ".mem_en"},   mem_enable, 0);
        chk({tag, ".mem_wr"},   mem_wr, 0);
    endtask

    // Called at the negedge of an IDLE cycle with requests already driven.
    // Follows one full transaction and returns at the negedge of the
    // following IDLE cycle.
    task automatic serve_one(input int raise_d_at, input bit keep);
        bit          win_d;
        logic [15:0] base;
        int          w;
        bit          issue, valid, last;
        chk_quiet("idle");
        win_d = d_req && !(i_req && model_last_d);
        model_last_d = win_d;
        if (win_d && d_wr) begin
            @(negedge clk);
            chk("wr.d_grant", d_grant, 1);
            chk("wr.i_grant", i_grant, 0);
            chk("wr.mem_en",  mem_enable, 1);
            chk("wr.mem_wr",  mem_wr, 1);
            chk("wr.addr",    mem_addr, d_addr);
            chk("wr.data",    mem_data_out, d_wdata);
            chk("wr.d_done",  d_done, 1);
            chk("wr.d_valid", d_data_valid, 0);
            ref_ov[d_addr[8:1]] = d_wdata ^ base_word(d_addr);
            if (!keep) d_req = 1'b0;
        end else begin
            base = (win_d ? d_addr : i_addr) & 16'hFFF0;
            for (int k = 1; k <= WORDS + MEM_LAT; k++) begin
                @(negedge clk);
                issue = (k <= WORDS);
                valid = (k > MEM_LAT);
                last  = (k == WORDS + MEM_LAT);
                w     = k - MEM_LAT - 1;
                chk("fill.i_grant", i_grant, !win_d);
                chk("fill.d_grant", d_grant, win_d);
                chk("fill.mem_en",  mem_enable, issue);
                chk("fill.mem_wr",  mem_wr, 0);
                chk("fill.addr",    mem_addr, issue ? base + 16'((k - 1) * 2) : 16'h0000);
                chk("fill.i_valid", i_data_valid, valid && !win_d);
                chk("fill.d_valid", d_data_valid, valid && win_d);
                chk("fill.i_done",  i_done, last && !win_d);
                chk("fill.d_done",  d_done, last && win_d);
                if (valid) begin
                    chk("fill.word", fill_word, 16'(w));
                    chk("fill.data", fill_data, ref_word(base + 16'(w * 2)));
                end
                if (k == raise_d_at) begin
                    d_req  = 1'b1;
                    d_wr   = 1'b0;
                    d_addr = 16'($urandom);
                end
            end
            if (!keep) begin
                if (win_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_ov[i] = 16'h0000;
        model_last_d = 1'b0;
        rst = 1'b1; inject = 1'b0;
        i_req = 1'b0; i_addr = 16'h0000;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset.addr",  mem_addr, 0);
        chk("reset.word",  fill_word, 0);
        chk("reset.wdata", mem_data_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // I-only refill from 0x1236
        i_req = 1'b1; i_addr = 16'h1236;
        serve_one(0, 1'b0);

        // Simultaneous after reset: D first, then I
        i_req = 1'b1; i_addr = 16'($urandom);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4000;
        serve_one(0, 1'b0);
        serve_one(0, 1'b0);

        // D alone, then both: last_d forces I first
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
        serve_one(0, 1'b0);
        i_req = 1'b1; i_addr = 16'($urandom);
        d_req = 1'b1; d_addr = 16'($urandom);
        serve_one(0, 1'b0);
        serve_one(0, 1'b0);

        // Both held continuously: grants alternate
        i_req = 1'b1; i_addr = 16'($urandom);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
        repeat (4) serve_one(0, 1'b1);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // D write, then read it back through an I refill
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0102; d_wdata = 16'hBEEF;
        serve_one(0, 1'b0);
        i_req = 1'b1; i_addr = 16'h0100;
        serve_one(0, 1'b0);

        // D request arriving at T+3 of an I refill waits for IDLE
        i_req = 1'b1; i_addr = 16'($urandom);
        serve_one(3, 1'b0);
        serve_one(0, 1'b0);

        // Reset in the middle of a D refill
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
        chk_quiet("prerst");
        repeat (6) @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk_quiet("midrst");
        chk("midrst.addr", mem_addr, 0);
        chk("midrst.word", fill_word, 0);
        rst = 1'b0; model_last_d = 1'b0;
        for (int i = 0; i < 256; i++) ref_ov[i] = 16'h0000;
        inject = 1'b1;
        @(negedge clk);
        chk("late.d_valid", d_data_valid, 0);
        chk("late.d_done",  d_done, 0);
        chk("late.i_valid", i_data_valid, 0);
        inject = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'($urandom);
        serve_one(0, 1'b0);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            if (!i_req && ($urandom_range(0, 1) == 1)) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            if (!d_req && ($urandom_range(0, 1) == 1)) begin
                d_req = 1'b1; d_wr = ($urandom_range(0, 2) == 0);
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if (!i_req && !d_req) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            serve_one(0, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
